hil_axil_regs: RTL

//   AXI4-Lite slave register file for the HIL controller IP; direct downstream consumer of the
//   S00_AXI master (PS interconnect or VIP master in the BFM bench). Holds 4 x 32-bit R/W

---
 rtl/hil_axil_regs.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hil_axil_regs.sv
// hil_axil_regs: AXI4-Lite slave holding four 32-bit control registers for the HIL core.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET   clock (rising edge), asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W*        write address / data channels, each with a one-entry buffer
//   S_AXI_B*                    write response, always OKAY, held until BREADY
//   S_AXI_AR* / S_AXI_R*        read address / data channels, always OKAY, held until RREADY
//   regs_o                      {reg3, reg2, reg1, reg0} to the HIL core
//   wr_pulse_o                  one-hot single-cycle strobe for the register just written
module hil_axil_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [3:0]                      wr_pulse_o
);

    localparam int unsigned NumBytes = C_S_AXI_DATA_WIDTH / 8;

    // Register file
    logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;

    // Write path buffers
    logic                          aw_full_q, aw_full_d;
    logic [1:0]                    aw_idx_q, aw_idx_d;
    logic                          w_full_q, w_full_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [NumBytes-1:0]           w_strb_q, w_strb_d;
    logic                          awready_q, wready_q;
    logic                          bvalid_q, bvalid_d;
    logic [3:0]                    wr_pulse_q, wr_pulse_d;

    // Read path
    logic                          arready_q, arready_d;
    logic                          rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic aw_hs, w_hs, ar_hs, commit;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs  = S_AXI_AWVALID & awready_q;
    assign w_hs   = S_AXI_WVALID & wready_q;
    assign ar_hs  = S_AXI_ARVALID & arready_q;
    // A new response may only be raised once the previous one is gone or leaving this edge.
    assign commit = aw_full_q & w_full_q & (~bvalid_q | S_AXI_BREADY);

    always_comb begin
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        regs_d     = regs_q;
        wr_pulse_d = 4'b0000;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            for (int b = 0; b < NumBytes; b++) begin
                if (w_strb_q[b]) begin
                    regs_d[aw_idx_q][8*b +: 8] = w_data_q[8*b +: 8];
                end
            end
            wr_pulse_d = 4'b0001 << aw_idx_q;
        end else begin
            // Readies equal buffer-empty, so a handshake never lands on a full buffer.
            if (aw_hs) begin
                aw_full_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
                w_full_d = 1'b1;
                w_data_d = S_AXI_WDATA;
                w_strb_d = S_AXI_WSTRB;
            end
        end

        if (commit) begin
            bvalid_d = 1'b1;
        end else if (S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        // Reads sample regs_q, so a same-cycle commit is not visible yet.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
            rdata_d  = '0;
        end
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            regs_q     <= '0;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= 2'd0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            wr_pulse_q <= 4'b0000;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            regs_q     <= regs_d;
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= ~aw_full_d;
            wready_q   <= ~w_full_d;
            bvalid_q   <= bvalid_d;
            wr_pulse_q <= wr_pulse_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign regs_o        = regs_q;
    assign wr_pulse_o    = wr_pulse_q;

endmodule
